// File: rtl/rs_dec_syndrome.sv
// ---------------------------------------------------------------------------
// rs_dec_syndrome
// Syndrome calculator for an RS(N, N-NSYM) decoder over GF(2^M), with
// primitive polynomial x^10 + x^3 + 1 and alpha = 10'h002.
// S_j = r(alpha^j) for j = 0..NSYM-1, evaluated by Horner's rule as symbols
// arrive, highest-degree coefficient first.
//
// Ports
//   clk           : clock, all state on rising edge
//   rst_n         : asynchronous active-low reset
//   in_valid      : in_data carries a symbol this cycle
//   in_sop        : first symbol of a codeword (qualified by in_valid)
//   in_data       : received symbol, r(N-1) first
//   syn_valid     : one-cycle pulse, syndromes_out holds a fresh result
//   syndromes_out : S0..S(NSYM-1), index j holds S_j; held until next result
//   syn_nonzero   : OR of all syndromes, valid with syn_valid
//   sop_err       : one-cycle pulse on a framing violation
// ---------------------------------------------------------------------------
module rs_dec_syndrome #(
  parameter int unsigned N    = 544,
  parameter int unsigned NSYM = 30,
  parameter int unsigned M    = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic [M-1:0]           in_data,
  output logic                   syn_valid,
  output logic [NSYM-1:0][M-1:0] syndromes_out,
  output logic                   syn_nonzero,
  output logic                   sop_err
);

  localparam int unsigned CW = $clog2(N + 1);

  // Low-order terms of the primitive polynomial (x^3 + 1), folded back in
  // whenever the x^M term overflows.
  localparam logic [M-1:0] POLY_LOW = {{(M-4){1'b0}}, 4'b1001};

  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY_LOW : '0);
  endfunction

  // Multiply by alpha^p; p is an elaboration-time constant at every call
  // site, so this collapses to a fixed XOR network.
  function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] x,
                                                 input int unsigned p);
    logic [M-1:0] r;
    r = x;
    for (int unsigned i = 0; i < p; i++) r = mul_alpha(r);
    return r;
  endfunction

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NSYM-1:0][M-1:0] acc_q, acc_d, acc_mul;
  logic                   syn_load;
  logic                   err_d;

  for (genvar j = 0; j < NSYM; j++) begin : g_cmul
    assign acc_mul[j] = mul_alpha_pow(acc_q[j], j);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    syn_load = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_sop) begin
            acc_d   = {NSYM{in_data}};
            cnt_d   = CW'(1);
            state_d = ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (in_sop) begin
            // Abort: restart on this symbol, never report the old codeword.
            err_d = 1'b1;
            acc_d = {NSYM{in_data}};
            cnt_d = CW'(1);
          end else begin
            for (int unsigned j = 0; j < NSYM; j++) acc_d[j] = acc_mul[j] ^ in_data;
            if (cnt_q == CW'(N - 1)) begin
              syn_load = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      syndromes_out <= '0;
      syn_valid     <= 1'b0;
      syn_nonzero   <= 1'b0;
      sop_err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      syn_valid <= syn_load;
      sop_err   <= err_d;
      if (syn_load) begin
        syndromes_out <= acc_d;
        syn_nonzero   <= |acc_d;
      end
    end
  end

endmodule

// File: doc/rs_dec_syndrome.md
RS_DEC_SYNDROME -- requirements
Module: rs_dec_syndrome

Interface
REQ-001 SHALL have parameter N, default 544: codeword length in symbols, RS(544,514) over GF(2^10).
REQ-002 SHALL have parameter NSYM, default 30: number of syndromes (2T, T=15).
REQ-003 SHALL have parameter M, default 10: symbol width in bits.
REQ-004 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1: in_data carries a symbol this cycle.
REQ-007 SHALL have port in_sop  input  1: qualified by in_valid; first symbol of a codeword.
REQ-008 SHALL have port in_data  input  M: received symbol, highest-degree coefficient r(N-1) first.
REQ-009 SHALL have port syn_valid  output  1: one-cycle pulse, syndromes_out complete; drives the KES start input.
REQ-010 SHALL have port syndromes_out  output  NSYM x M: S0..S29, registered.
REQ-011 SHALL have port syn_nonzero  output  1: valid with syn_valid; any syndrome nonzero.
REQ-012 SHALL have port sop_err  output  1: one-cycle pulse on protocol violation.

Function
REQ-013 SHALL perform GF(2^10) arithmetic with primitive polynomial x^10+x^3+1 and alpha = 10'h002.
REQ-014 SHALL define S_j = r(alpha^j), j = 0..NSYM-1.
REQ-015 SHALL keep NSYM accumulators acc_j, computed by Horner: on an accepted non-first symbol, acc_j <= (acc_j * alpha^j) XOR in_data.
REQ-016 SHALL implement each multiply by alpha^j as a constant GF multiplier, one per syndrome.
REQ-017 SHALL implement state machine IDLE/ACCUM.
REQ-018 IDLE: on in_valid&in_sop, SHALL set acc_j <= in_data for all j, sym_cnt <= 1, go to ACCUM.
REQ-019 IDLE: SHALL ignore in_valid without in_sop and pulse sop_err.
REQ-020 ACCUM: on in_valid&!in_sop, SHALL Horner-update and increment sym_cnt.
REQ-021 ACCUM: on in_valid&in_sop, SHALL abort the current codeword, pulse sop_err, and restart as in REQ-018; it SHALL NOT produce syn_valid for the aborted codeword.
REQ-022 SHALL hold acc_j and sym_cnt when in_valid=0; gaps of any length are allowed.
REQ-023 On acceptance of the symbol at sym_cnt==N-1, the next cycle SHALL present: syndromes_out = final accumulator values, syn_valid=1 for exactly one cycle, syn_nonzero = OR of all syndromes, state IDLE.
REQ-024 Latency SHALL be 1 cycle from the last symbol to syn_valid.
REQ-025 syndromes_out SHALL hold until the next completed codeword; aborted codewords SHALL NOT change it.
REQ-026 SHALL accept a new in_sop in the same cycle syn_valid is high, giving back-to-back codewords with zero bubble.
REQ-027 sym_cnt SHALL be ceil(log2(N+1)) bits and SHALL never exceed N-1.

Reset
REQ-028 rst_n low SHALL asynchronously set state=IDLE, sym_cnt=0, all acc_j=0, syndromes_out=0, syn_valid=0, syn_nonzero=0, sop_err=0.
REQ-029 Reset mid-codeword SHALL discard the partial codeword; the first sop after release SHALL start cleanly.

Verification
REQ-030 All-zero 544-symbol codeword -> syn_valid 1 cycle after the last symbol; all S_j=0; syn_nonzero=0.
REQ-031 Zeros with last symbol 10'h005 -> all 30 S_j=10'h005; syn_nonzero=1.
REQ-032 Zeros with first symbol 10'h001 (degree 543) -> S0=10'h001, S_j=alpha^(543j mod 1023), checked against a software model.
REQ-033 Valid codeword from the reference encoder with random in_valid gaps -> all S_j=0; result identical to a gapless run.
REQ-034 in_sop at symbol 200 -> sop_err pulse; no syn_valid for the aborted codeword; the following codeword gives correct syndromes; prior syndromes_out unchanged meanwhile.
REQ-035 Two back-to-back codewords (sop in the syn_valid cycle), then rst_n pulsed at symbol 300 of a third -> first two results correct, all outputs 0 after reset, next codeword correct.
